// File: rtl/dcache_refill_ctrl.sv
// Data-cache refill controller: word read, one-cycle fill, dirty-victim write-back.
// Optional memory-wait timeout is built in when DCACHE_REFILL_TIMEOUT_EN is defined.
module dcache_refill_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        CLK_cpu,
  input  logic        RST_cpu_n,
  input  logic        cache_miss,
  input  logic [19:0] miss_addr,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        fetch,
  output logic [19:0] fill_addr,
  output logic [31:0] fill_data,
  input  logic [15:0] victim_tag,
  input  logic [31:0] victim_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [19:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned AW = 20;
  localparam int unsigned DW = 32;
  localparam int unsigned VW = 10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MEM_RD  = 3'd1,
    FILL    = 3'd2,
    CAPTURE = 3'd3,
    WB      = 3'd4,
    DONE    = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic [VW-1:0] vtag_q, vtag_d;
  logic [DW-1:0] vdata_q, vdata_d;
  logic          timeout_c;

  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          fetch_q, fetch_d;
  logic [AW-1:0] fill_addr_q, fill_addr_d;
  logic [DW-1:0] fill_data_q, fill_data_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;

  // Only the valid/dirty flags and the low tag field take part in the refill.
  logic unused_tag_bits;
  assign unused_tag_bits = ^{victim_tag[15:14], victim_tag[11:10]};

`ifdef DCACHE_REFILL_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  assign timeout_c = ((state_q == MEM_RD) || (state_q == WB)) && !mem_ack &&
                     (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Wait counter restarts from zero on every entry into a wait state.
  always_comb begin
    cnt_d = '0;
    err_d = timeout_c;
    if ((state_d == state_q) && ((state_q == MEM_RD) || (state_q == WB))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK_cpu or negedge RST_cpu_n) begin
    if (!RST_cpu_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_timeout_param;
  assign unused_timeout_param = (TIMEOUT_CYCLES == 0);
  assign timeout_c = 1'b0;
  assign err       = 1'b0;
`endif

  // Next-state and data capture.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    vtag_d  = vtag_q;
    vdata_d = vdata_q;
    unique case (state_q)
      IDLE: begin
        if (cache_miss) begin
          addr_d  = miss_addr;
          state_d = MEM_RD;
        end
      end
      MEM_RD: begin
        if (mem_ack) begin
          data_d  = mem_rdata;
          state_d = FILL;
        end else if (timeout_c) begin
          state_d = IDLE;
        end
      end
      FILL: state_d = CAPTURE;
      CAPTURE: begin
        vtag_d  = victim_tag[VW-1:0];
        vdata_d = victim_data;
        state_d = (victim_tag[13] && victim_tag[12]) ? WB : DONE;
      end
      WB: begin
        if (mem_ack) begin
          state_d = DONE;
        end else if (timeout_c) begin
          state_d = IDLE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    busy_d      = 1'b0;
    done_d      = 1'b0;
    fetch_d     = 1'b0;
    fill_addr_d = '0;
    fill_data_d = '0;
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    unique case (state_d)
      MEM_RD: begin
        busy_d     = 1'b1;
        mem_req_d  = 1'b1;
        mem_addr_d = {addr_d[AW-1:2], 2'b00};
      end
      FILL: begin
        busy_d      = 1'b1;
        fetch_d     = 1'b1;
        fill_addr_d = addr_d;
        fill_data_d = data_d;
      end
      CAPTURE: busy_d = 1'b1;
      WB: begin
        busy_d      = 1'b1;
        mem_req_d   = 1'b1;
        mem_we_d    = 1'b1;
        mem_addr_d  = {vtag_d, addr_d[9:2], 2'b00};
        mem_wdata_d = vdata_d;
      end
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK_cpu or negedge RST_cpu_n) begin
    if (!RST_cpu_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      vtag_q      <= '0;
      vdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fetch_q     <= 1'b0;
      fill_addr_q <= '0;
      fill_data_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      vtag_q      <= vtag_d;
      vdata_q     <= vdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fetch_q     <= fetch_d;
      fill_addr_q <= fill_addr_d;
      fill_data_q <= fill_data_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign fetch     = fetch_q;
  assign fill_addr = fill_addr_q;
  assign fill_data = fill_data_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
